// File: rtl/rr_grant_arbiter_pkg.sv
// Shared NOC router definitions: arbiter FSM state and the default port/flit
// geometry used as parameter defaults across the router.
package rr_grant_arbiter_pkg;

  localparam int NOC_PORTS      = 4;
  localparam int NOC_FLIT_WIDTH = 32;
  localparam int NOC_MAX_FLITS  = 16;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_grant_arbiter_pick.sv
// Combinational cyclic priority scan: starting at the priority index, return
// the first requesting input, wrapping around past N-1.
module rr_pick
  import rr_grant_arbiter_pkg::*;
#(
  parameter int N = NOC_PORTS,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     priority_order,
  output logic [IDX_W-1:0] winner,
  output logic             any_valid
);

  int   p_idx;
  int   scan_idx;
  logic found;

  always_comb begin
    p_idx    = 0;
    scan_idx = 0;
    found    = 1'b0;
    winner   = '0;
    // Descending scan leaves the lowest set bit; an all-zero vector means 0.
    for (int i = N - 1; i >= 0; i--) begin
      if (priority_order[i]) p_idx = i;
    end
    for (int k = 0; k < N; k++) begin
      scan_idx = p_idx + k;
      if (scan_idx >= N) scan_idx = scan_idx - N;
      if (!found && req[IDX_W'(scan_idx)]) begin
        found  = 1'b1;
        winner = IDX_W'(scan_idx);
      end
    end
    any_valid = |req;
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Wormhole output-port arbiter: grants one requester per packet (head..tail),
// muxes its flits downstream and requests a priority rotation on release.
module rr_grant_arbiter
  import rr_grant_arbiter_pkg::*;
#(
  parameter int N          = NOC_PORTS,
  parameter int DATA_WIDTH = NOC_FLIT_WIDTH,
  parameter int MAX_FLITS  = NOC_MAX_FLITS,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1,
  localparam int CNT_W = $clog2(MAX_FLITS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N-1:0]          req_i,
  input  logic [N-1:0]          last_i,
  input  logic [N*DATA_WIDTH-1:0] data_i,
  input  logic [N-1:0]          priority_order_i,
  input  logic                  out_ready_i,
  output logic                  out_valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [N-1:0]          grant_o,
  output logic                  change_order_o,
  output logic                  err_o,
  output arb_state_t            state_o
);

  // Downstream handshake: a flit moves when out_valid_o and out_ready_i are
  // both high in the same cycle; out_valid_o never looks at out_ready_i.

  arb_state_t       state;
  logic [IDX_W-1:0] sel;
  logic [CNT_W-1:0] flit_cnt;
  logic [IDX_W-1:0] win;
  logic             any_valid;
  logic             xfer;
  logic             cnt_max;
  logic             release_pkt;

  rr_pick #(.N(N)) u_pick (
    .req            (req_i),
    .priority_order (priority_order_i),
    .winner         (win),
    .any_valid      (any_valid)
  );

  assign out_valid_o    = (state == LOCK) && req_i[sel];
  assign xfer           = out_valid_o && out_ready_i;
  assign cnt_max        = (flit_cnt == CNT_W'(MAX_FLITS - 1));
  assign release_pkt    = xfer && (last_i[sel] || cnt_max);
  // A release coinciding with reset must not rotate the priority register.
  assign change_order_o = release_pkt && !reset;
  assign data_o         = out_valid_o ? data_i[sel*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign state_o        = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      sel      <= '0;
      flit_cnt <= '0;
      grant_o  <= '0;
      err_o    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            sel      <= win;
            grant_o  <= N'(1) << win;
            flit_cnt <= '0;
            state    <= LOCK;
          end
        end
        LOCK: begin
          if (xfer) begin
            flit_cnt <= flit_cnt + 1'b1;
            if (release_pkt) begin
              state   <= IDLE;
              grant_o <= '0;
              if (!last_i[sel]) err_o <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
